// File: rtl/match_pkg.sv
// Shared definitions for the match controller: FSM state encodings,
// match_winner codes, parameter defaults and small saturating helpers.
package match_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_COUNTDOWN  = 3'd1,
        ST_FIGHT      = 3'd2,
        ST_ROUND_OVER = 3'd3,
        ST_MATCH_OVER = 3'd4
    } state_e;

    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_P1   = 2'b01;
    localparam logic [1:0] WIN_P2   = 2'b11;

    localparam int DEF_TICK_DIV      = 100_000_000;
    localparam int DEF_COUNTDOWN_S   = 3;
    localparam int DEF_ROUNDS_TO_WIN = 2;
    localparam int DEF_KO_HOLD_S     = 2;
    localparam int DEF_ROUND_TIME_S  = 60;

    // Round-win tally increment that stops at the match target.
    function automatic logic [1:0] sat_inc_tally(input logic [1:0] v, input logic [1:0] lim);
        return (v < lim) ? (v + 2'd1) : v;
    endfunction

    // Round number increment that stops at the largest displayable round.
    function automatic logic [2:0] sat_inc_round(input logic [2:0] v);
        return (v == 3'd7) ? v : (v + 3'd1);
    endfunction

endpackage

// File: rtl/match_controller_sec_tick.sv
// One-second tick generator: counts TICK_DIV clocks and flags the last one.
// clr restarts the second so every FSM state begins on a full second.
module sec_tick #(
    parameter int TICK_DIV = 100_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    output logic tick
);

    localparam int            CW      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_r;

    // Divider counter: cleared on reset or state entry, wraps after the tick cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_r <= {CW{1'b0}};
        end else if (clr) begin
            cnt_r <= {CW{1'b0}};
        end else if (cnt_r == CNT_MAX) begin
            cnt_r <= {CW{1'b0}};
        end else begin
            cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
        end
    end

    assign tick = (cnt_r == CNT_MAX);

endmodule

// File: rtl/match_controller.sv
// Match controller: sequences IDLE -> COUNTDOWN -> FIGHT -> ROUND_OVER ->
// MATCH_OVER for a two-player fighting game core and keeps round tallies.
// Optional round time limit: define ROUND_TIMER_EN.
module match_controller
    import match_pkg::*;
#(
    parameter int TICK_DIV      = DEF_TICK_DIV,
    parameter int COUNTDOWN_S   = DEF_COUNTDOWN_S,
    parameter int ROUNDS_TO_WIN = DEF_ROUNDS_TO_WIN,
    parameter int KO_HOLD_S     = DEF_KO_HOLD_S,
    parameter int ROUND_TIME_S  = DEF_ROUND_TIME_S
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start_btn,
    input  logic [1:0] finish,
    input  logic [3:0] p1_health,
    input  logic [3:0] p2_health,
    output logic       game_rst_l,
    output logic       freeze,
    output logic [2:0] state,
    output logic [3:0] countdown,
    output logic [1:0] p1_rounds,
    output logic [1:0] p2_rounds,
    output logic [2:0] round_num,
    output logic [1:0] match_winner,
    output logic [6:0] time_left
);

    localparam logic [3:0] CD_LOAD  = 4'(COUNTDOWN_S);
    localparam logic [1:0] R2W      = 2'(ROUNDS_TO_WIN);
    localparam int         KO_TICKS = (KO_HOLD_S < 1) ? 1 : KO_HOLD_S;
    localparam logic [7:0] KO_LAST  = 8'(KO_TICKS - 1);

    state_e     state_r, state_s;
    logic [3:0] countdown_r, countdown_s;
    logic [1:0] p1_rounds_r, p1_rounds_s;
    logic [1:0] p2_rounds_r, p2_rounds_s;
    logic [2:0] round_num_r, round_num_s;
    logic [1:0] winner_r, winner_s;
    logic [7:0] hold_r, hold_s;
    logic       game_rst_l_r, game_rst_l_s;
    logic       freeze_r, freeze_s;
    logic       start_prev_r;
    logic       start_rise_s;
    logic       tick_s;
    logic       clr_s;
    logic       replay_s;

`ifdef ROUND_TIMER_EN
    localparam logic [6:0] RT_LOAD = 7'(ROUND_TIME_S);
    logic [6:0] time_left_r, time_left_s;
    logic       draw_r, draw_s;
    assign replay_s  = draw_r;
    assign time_left = time_left_r;
`else
    logic unused_timer_s;
    assign unused_timer_s = (^{p1_health, p2_health}) ^ (ROUND_TIME_S > 0);
    assign replay_s       = 1'b0;
    assign time_left      = 7'd0;
`endif

    // Start held through reset release is not an edge: prev resets high.
    assign start_rise_s = start_btn & ~start_prev_r;
    // Restart the second on every state change.
    assign clr_s        = (state_s != state_r);

    sec_tick #(
        .TICK_DIV (TICK_DIV)
    ) u_sec_tick (
        .clk   (clk),
        .reset (reset),
        .clr   (clr_s),
        .tick  (tick_s)
    );

    // Next-state and datapath decode; every register holds unless updated.
    always_comb begin
        state_s     = state_r;
        countdown_s = countdown_r;
        p1_rounds_s = p1_rounds_r;
        p2_rounds_s = p2_rounds_r;
        round_num_s = round_num_r;
        winner_s    = winner_r;
        hold_s      = hold_r;
`ifdef ROUND_TIMER_EN
        time_left_s = time_left_r;
        draw_s      = draw_r;
`endif
        case (state_r)
            ST_IDLE: begin
                if (start_rise_s) begin
                    state_s     = ST_COUNTDOWN;
                    countdown_s = CD_LOAD;
                    p1_rounds_s = 2'd0;
                    p2_rounds_s = 2'd0;
                    round_num_s = 3'd1;
                    winner_s    = WIN_NONE;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_COUNTDOWN: begin
                if (tick_s) begin
                    if (countdown_r <= 4'd1) begin
                        countdown_s = 4'd0;
                        state_s     = ST_FIGHT;
`ifdef ROUND_TIMER_EN
                        time_left_s = RT_LOAD;
`endif
                    end else begin
                        countdown_s = countdown_r - 4'd1;
                    end
                end else begin
                    countdown_s = countdown_r;
                end
            end
            ST_FIGHT: begin
                // A reported KO outranks a timer expiry on the same cycle.
                if (finish[0]) begin
                    state_s = ST_ROUND_OVER;
                    hold_s  = 8'd0;
`ifdef ROUND_TIMER_EN
                    draw_s  = 1'b0;
`endif
                    if (finish[1]) begin
                        p2_rounds_s = sat_inc_tally(p2_rounds_r, R2W);
                    end else begin
                        p1_rounds_s = sat_inc_tally(p1_rounds_r, R2W);
                    end
                end
`ifdef ROUND_TIMER_EN
                else if (tick_s) begin
                    if (time_left_r <= 7'd1) begin
                        time_left_s = 7'd0;
                        state_s     = ST_ROUND_OVER;
                        hold_s      = 8'd0;
                        draw_s      = 1'b0;
                        if (p1_health > p2_health) begin
                            p1_rounds_s = sat_inc_tally(p1_rounds_r, R2W);
                        end else if (p2_health > p1_health) begin
                            p2_rounds_s = sat_inc_tally(p2_rounds_r, R2W);
                        end else begin
                            draw_s = 1'b1;
                        end
                    end else begin
                        time_left_s = time_left_r - 7'd1;
                    end
                end
`endif
                else begin
                    state_s = ST_FIGHT;
                end
            end
            ST_ROUND_OVER: begin
                if (tick_s) begin
                    if (hold_r == KO_LAST) begin
                        if ((p1_rounds_r == R2W) || (p2_rounds_r == R2W)) begin
                            state_s  = ST_MATCH_OVER;
                            winner_s = (p1_rounds_r == R2W) ? WIN_P1 : WIN_P2;
                        end else begin
                            state_s     = ST_COUNTDOWN;
                            countdown_s = CD_LOAD;
                            // A drawn round is replayed under the same number.
                            if (replay_s) begin
                                round_num_s = round_num_r;
                            end else begin
                                round_num_s = sat_inc_round(round_num_r);
                            end
                        end
                    end else begin
                        hold_s = hold_r + 8'd1;
                    end
                end else begin
                    hold_s = hold_r;
                end
            end
            ST_MATCH_OVER: begin
                if (start_rise_s) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_MATCH_OVER;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Game-core control levels decoded from the state being entered.
    always_comb begin
        game_rst_l_s = 1'b0;
        freeze_s     = 1'b1;
        case (state_s)
            ST_FIGHT: begin
                game_rst_l_s = 1'b1;
                freeze_s     = 1'b0;
            end
            ST_ROUND_OVER, ST_MATCH_OVER: begin
                game_rst_l_s = 1'b1;
                freeze_s     = 1'b1;
            end
            default: begin
                game_rst_l_s = 1'b0;
                freeze_s     = 1'b1;
            end
        endcase
    end

    // State and datapath registers; reset aborts everything with no tally update.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            countdown_r  <= 4'd0;
            p1_rounds_r  <= 2'd0;
            p2_rounds_r  <= 2'd0;
            round_num_r  <= 3'd0;
            winner_r     <= WIN_NONE;
            hold_r       <= 8'd0;
            game_rst_l_r <= 1'b0;
            freeze_r     <= 1'b1;
            start_prev_r <= 1'b1;
`ifdef ROUND_TIMER_EN
            time_left_r  <= 7'd0;
            draw_r       <= 1'b0;
`endif
        end else begin
            state_r      <= state_s;
            countdown_r  <= countdown_s;
            p1_rounds_r  <= p1_rounds_s;
            p2_rounds_r  <= p2_rounds_s;
            round_num_r  <= round_num_s;
            winner_r     <= winner_s;
            hold_r       <= hold_s;
            game_rst_l_r <= game_rst_l_s;
            freeze_r     <= freeze_s;
            start_prev_r <= start_btn;
`ifdef ROUND_TIMER_EN
            time_left_r  <= time_left_s;
            draw_r       <= draw_s;
`endif
        end
    end

    assign state        = state_r;
    assign countdown    = countdown_r;
    assign p1_rounds    = p1_rounds_r;
    assign p2_rounds    = p2_rounds_r;
    assign round_num    = round_num_r;
    assign match_winner = winner_r;
    assign game_rst_l   = game_rst_l_r;
    assign freeze       = freeze_r;

endmodule

// File: tb/tb_match_controller.sv
// Scoreboard bench for match_controller (TICK_DIV=4, COUNTDOWN_S=3,
// KO_HOLD_S=2, ROUNDS_TO_WIN=2, ROUND_TIME_S=2). Every change of the output
// tuple is one DUT event; the stimulus pushes the expected event sequence.
module tb_match_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic       start_btn;
    logic [1:0] finish;
    logic [3:0] p1_health, p2_health;
    logic       game_rst_l, freeze;
    logic [2:0] state;
    logic [3:0] countdown;
    logic [1:0] p1_rounds, p2_rounds;
    logic [2:0] round_num;
    logic [1:0] match_winner;
    logic [6:0] time_left;

    localparam logic [2:0] S_IDLE = 3'd0, S_CD = 3'd1, S_FIGHT = 3'd2, S_RO = 3'd3, S_MO = 3'd4;
`ifdef ROUND_TIMER_EN
    localparam int TLX = -1;
    localparam int TLF = 2;
`else
    localparam int TLX = 0;
    localparam int TLF = 0;
`endif

    match_controller #(
        .TICK_DIV(4), .COUNTDOWN_S(3), .ROUNDS_TO_WIN(2), .KO_HOLD_S(2), .ROUND_TIME_S(2)
    ) dut (
        .clk(clk), .reset(reset), .start_btn(start_btn), .finish(finish),
        .p1_health(p1_health), .p2_health(p2_health), .game_rst_l(game_rst_l),
        .freeze(freeze), .state(state), .countdown(countdown), .p1_rounds(p1_rounds),
        .p2_rounds(p2_rounds), .round_num(round_num), .match_winner(match_winner),
        .time_left(time_left)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] st;
        logic [3:0] cd;
        logic [1:0] p1;
        logic [1:0] p2;
        logic [2:0] rn;
        logic [1:0] w;
        int         tl;   // negative: don't care
        int         dt;   // cycles since previous event, 0: don't care
        bit         data; // 0: only state and control levels are checked
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0, failures = 0, cyc = 0, last_cyc = 0, ev_n = 0;
    bit   mon_en = 1'b0, first = 1'b1;
    logic [24:0] prev_snap, cur_snap;
    exp_t e;
    bit   ok;

    // Expected {game_rst_l, freeze} for a state.
    function automatic logic [1:0] ctl_of(input logic [2:0] st);
        case (st)
            3'd2:       return 2'b10;
            3'd3, 3'd4: return 2'b11;
            default:    return 2'b01;
        endcase
    endfunction

    function automatic void push(input logic [2:0] st, input logic [3:0] cd, input logic [1:0] p1,
                                 input logic [1:0] p2, input logic [2:0] rn, input logic [1:0] w,
                                 input int tl, input int dt, input bit data);
        exp_t x;
        x.st = st; x.cd = cd; x.p1 = p1; x.p2 = p2; x.rn = rn; x.w = w;
        x.tl = tl; x.dt = dt; x.data = data;
        exp_q.push_back(x);
    endfunction

    // Countdown 3,2,1 then FIGHT, one second (4 cycles) apart.
    function automatic void exp_countdown(input logic [1:0] p1, input logic [1:0] p2,
                                          input logic [2:0] rn, input int dt_first);
        push(S_CD, 4'd3, p1, p2, rn, 2'b00, TLX, dt_first, 1'b1);
        push(S_CD, 4'd2, p1, p2, rn, 2'b00, TLX, 4, 1'b1);
        push(S_CD, 4'd1, p1, p2, rn, 2'b00, TLX, 4, 1'b1);
        push(S_FIGHT, 4'd0, p1, p2, rn, 2'b00, TLF, 4, 1'b1);
    endfunction

    // Monitor: on every output change pop one expected event and compare.
    always @(negedge clk) begin
        cyc = cyc + 1;
        cur_snap = {state, countdown, p1_rounds, p2_rounds, round_num, match_winner,
                    time_left, game_rst_l, freeze};
        if (mon_en && (first || (cur_snap !== prev_snap))) begin
            checks = checks + 1;
            if (exp_q.size() == 0) begin
                failures = failures + 1;
                $display("FAIL unexpected_event cyc=%0d got st=%0d cd=%0d p1=%0d p2=%0d rn=%0d w=%0d tl=%0d",
                         cyc, state, countdown, p1_rounds, p2_rounds, round_num, match_winner, time_left);
            end else begin
                e  = exp_q.pop_front();
                ev_n = ev_n + 1;
                ok = (state === e.st) && ({game_rst_l, freeze} === ctl_of(e.st));
                if (e.data)
                    ok = ok && (countdown === e.cd) && (p1_rounds === e.p1) && (p2_rounds === e.p2)
                            && (round_num === e.rn) && (match_winner === e.w);
                if (e.tl >= 0) ok = ok && (time_left === 7'(e.tl));
                if (e.dt > 0) ok = ok && ((cyc - last_cyc) == e.dt);
                if (!ok) begin
                    failures = failures + 1;
                    $display("FAIL ev%0d got st=%0d cd=%0d p1=%0d p2=%0d rn=%0d w=%0d tl=%0d grl=%0d frz=%0d dt=%0d exp st=%0d cd=%0d p1=%0d p2=%0d rn=%0d w=%0d tl=%0d ctl=%b dt=%0d data=%0d",
                             ev_n, state, countdown, p1_rounds, p2_rounds, round_num, match_winner,
                             time_left, game_rst_l, freeze, cyc - last_cyc, e.st, e.cd, e.p1, e.p2,
                             e.rn, e.w, e.tl, ctl_of(e.st), e.dt, e.data);
                end
            end
            prev_snap = cur_snap;
            last_cyc  = cyc;
            first     = 1'b0;
        end
    end

    task automatic press();
        @(posedge clk); #1 start_btn = 1'b1;
        @(posedge clk); #1 start_btn = 1'b0;
    endtask

    task automatic pulse_fin(input logic [1:0] f);
        @(posedge clk); #1 finish = f;
        @(posedge clk); #1 finish = 2'b00;
    endtask

    task automatic wait_state(input logic [2:0] s);
        int n = 0;
        while ((state !== s) && (n < 200)) begin
            @(negedge clk);
            n = n + 1;
        end
        if (state !== s) begin
            checks = checks + 1;
            failures = failures + 1;
            $display("FAIL wait_state got=%0d want=%0d", state, s);
        end
    endtask

    initial begin
        reset = 1'b1; start_btn = 1'b1; finish = 2'b00;
        p1_health = 4'd5; p2_health = 4'd5;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        // Reset state; start still held must not count as an edge.
        push(S_IDLE, 4'd0, 2'd0, 2'd0, 3'd0, 2'b00, 0, 0, 1'b1);
        mon_en = 1'b1;
        repeat (4) @(posedge clk);
        #1 start_btn = 1'b0;
        repeat (2) @(posedge clk);

        // Match 1: P1, P1.
        exp_countdown(2'd0, 2'd0, 3'd1, 0);
        press();
        wait_state(S_FIGHT);
        push(S_RO, 4'd0, 2'd1, 2'd0, 3'd1, 2'b00, TLX, 0, 1'b1);
        pulse_fin(2'b01);
        exp_countdown(2'd1, 2'd0, 3'd2, 8);
        wait_state(S_FIGHT);
        push(S_RO, 4'd0, 2'd2, 2'd0, 3'd2, 2'b00, TLX, 0, 1'b1);
        pulse_fin(2'b01);
        push(S_MO, 4'd0, 2'd2, 2'd0, 3'd2, 2'b01, TLX, 8, 1'b1);
        wait_state(S_MO);

        // Match 2: P2, P1, P2; start edges ignored in COUNTDOWN and FIGHT.
        push(S_IDLE, 4'd0, 2'd0, 2'd0, 3'd0, 2'b00, -1, 0, 1'b0);
        press();
        wait_state(S_IDLE);
        exp_countdown(2'd0, 2'd0, 3'd1, 0);
        press();
        wait_state(S_CD);
        press();
        wait_state(S_FIGHT);
        press();
        push(S_RO, 4'd0, 2'd0, 2'd1, 3'd1, 2'b00, TLX, 0, 1'b1);
        pulse_fin(2'b11);
        exp_countdown(2'd0, 2'd1, 3'd2, 8);
        wait_state(S_FIGHT);
        push(S_RO, 4'd0, 2'd1, 2'd1, 3'd2, 2'b00, TLX, 0, 1'b1);
        pulse_fin(2'b01);
        exp_countdown(2'd1, 2'd1, 3'd3, 8);
        wait_state(S_FIGHT);
        push(S_RO, 4'd0, 2'd1, 2'd2, 3'd3, 2'b00, TLX, 0, 1'b1);
        pulse_fin(2'b11);
        push(S_MO, 4'd0, 2'd1, 2'd2, 3'd3, 2'b11, TLX, 8, 1'b1);
        wait_state(S_MO);

        // Match 3: reset mid-FIGHT with p2_rounds=1 and a KO on the reset cycle.
        push(S_IDLE, 4'd0, 2'd0, 2'd0, 3'd0, 2'b00, -1, 0, 1'b0);
        press();
        wait_state(S_IDLE);
        exp_countdown(2'd0, 2'd0, 3'd1, 0);
        press();
        wait_state(S_FIGHT);
        push(S_RO, 4'd0, 2'd0, 2'd1, 3'd1, 2'b00, TLX, 0, 1'b1);
        pulse_fin(2'b11);
        exp_countdown(2'd0, 2'd1, 3'd2, 8);
        wait_state(S_FIGHT);
        push(S_IDLE, 4'd0, 2'd0, 2'd0, 3'd0, 2'b00, 0, 2, 1'b1);
        @(posedge clk); #1 reset = 1'b1; finish = 2'b01;
        @(posedge clk); #1 reset = 1'b0; finish = 2'b00;
        repeat (6) @(posedge clk);

`ifdef ROUND_TIMER_EN
        // Timer expiry with equal health: no credit, round replayed.
        exp_countdown(2'd0, 2'd0, 3'd1, 0);
        push(S_FIGHT, 4'd0, 2'd0, 2'd0, 3'd1, 2'b00, 1, 4, 1'b1);
        push(S_RO, 4'd0, 2'd0, 2'd0, 3'd1, 2'b00, 0, 4, 1'b1);
        press();
        wait_state(S_RO);
        // Replay: P1 healthier at expiry gets the round.
        exp_countdown(2'd0, 2'd0, 3'd1, 8);
        push(S_FIGHT, 4'd0, 2'd0, 2'd0, 3'd1, 2'b00, 1, 4, 1'b1);
        push(S_RO, 4'd0, 2'd1, 2'd0, 3'd1, 2'b00, 0, 4, 1'b1);
        wait_state(S_CD);
        p1_health = 4'd9; p2_health = 4'd3;
        wait_state(S_RO);
        // KO for P2 on the expiry cycle outranks P1's health lead.
        exp_countdown(2'd1, 2'd0, 3'd2, 8);
        push(S_FIGHT, 4'd0, 2'd1, 2'd0, 3'd2, 2'b00, 1, 4, 1'b1);
        push(S_RO, 4'd0, 2'd1, 2'd1, 3'd2, 2'b00, -1, 4, 1'b1);
        wait_state(S_FIGHT);
        begin
            int n = 0;
            while ((time_left !== 7'd1) && (n < 50)) begin
                @(negedge clk);
                n = n + 1;
            end
            if (time_left !== 7'd1) begin
                checks = checks + 1;
                failures = failures + 1;
                $display("FAIL wait_time_left got=%0d want=1", time_left);
            end
        end
        repeat (3) @(posedge clk);
        #1 finish = 2'b11;
        @(posedge clk); #1 finish = 2'b00;
        repeat (2) @(posedge clk);
`endif

        repeat (2) @(posedge clk);
        checks = checks + 1;
        if (exp_q.size() != 0) begin
            failures = failures + 1;
            $display("FAIL pending_events got=%0d want=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
